// File: rtl/aes_gf_pkg.sv
// GF(2^8) helpers shared by the AES MixColumns/InvMixColumns stages,
// plus the state encoding used by the iterative column engines.
package aes_gf_pkg;

    localparam logic [7:0] AES_POLY = 8'h1b;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (AES_POLY & {8{b[7]}});
    endfunction

    function automatic logic [7:0] gf_mul09(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = gf_xtime(b);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul0b(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = gf_xtime(b);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul0d(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = gf_xtime(b);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul0e(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = gf_xtime(b);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/inv_mcol_col.sv
// Combinational InvMixColumns of one 32-bit column; byte 0 is the MSB byte.
module inv_mcol_col
    import aes_gf_pkg::*;
(
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    logic [7:0] s0, s1, s2, s3;
    logic [7:0] r0, r1, r2, r3;

    assign s0 = col_in[31:24];
    assign s1 = col_in[23:16];
    assign s2 = col_in[15:8];
    assign s3 = col_in[7:0];

    assign r0 = gf_mul0e(s0) ^ gf_mul0b(s1) ^ gf_mul0d(s2) ^ gf_mul09(s3);
    assign r1 = gf_mul09(s0) ^ gf_mul0e(s1) ^ gf_mul0b(s2) ^ gf_mul0d(s3);
    assign r2 = gf_mul0d(s0) ^ gf_mul09(s1) ^ gf_mul0e(s2) ^ gf_mul0b(s3);
    assign r3 = gf_mul0b(s0) ^ gf_mul0d(s1) ^ gf_mul09(s2) ^ gf_mul0e(s3);

    assign col_out = {r0, r1, r2, r3};

endmodule

// File: rtl/inv_mcol.sv
// Iterative InvMixColumns: one 128-bit block per handshake, one column per
// cycle through a single shared column transform, result held until taken.
module inv_mcol
    import aes_gf_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; ready/valid outputs here are pure decodes of state_q.

    state_t        state_q, state_d;
    logic [127:0]  src_q, src_d;
    logic [127:0]  dst_q, dst_d;
    logic [1:0]    col_q, col_d;
    logic [31:0]   col_in;
    logic [31:0]   col_out;

    assign col_in = src_q[{col_q, 5'b00000} +: 32];

    inv_mcol_col u_col (
        .col_in  (col_in),
        .col_out (col_out)
    );

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        col_d   = col_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    src_d   = in_state;
                    col_d   = 2'd0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                dst_d[{col_q, 5'b00000} +: 32] = col_out;
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            col_q   <= col_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_state = dst_q;

endmodule

// File: tb/tb_inv_mcol.sv
// Bench for inv_mcol: directed vectors, backpressure, reset abort,
// back-to-back streaming and a randomized MixColumns round trip.
module tb_inv_mcol;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_state = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_state;

    int vectors = 0;
    int miscompares = 0;

    logic [127:0] exp_q[$];

    inv_mcol dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
    );

    always #5 clk = ~clk;

    // ---------------- reference model: generic GF(2^8) matrix product
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Circulant matrix with first row m (byte 0 = MSB) applied to every column.
    function automatic logic [127:0] circ(input logic [127:0] s, input logic [31:0] m);
        logic [127:0] r = '0;
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    r[c*32 + 24 - 8*i +: 8] = r[c*32 + 24 - 8*i +: 8] ^
                        gmul(m[24 - 8*((j - i + 4) % 4) +: 8], s[c*32 + 24 - 8*j +: 8]);
        return r;
    endfunction

    function automatic logic [127:0] ref_inv(input logic [127:0] s);
        return circ(s, 32'h0e0b0d09);
    endfunction

    function automatic logic [127:0] ref_fwd(input logic [127:0] s);
        return circ(s, 32'h02030101);
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer one block, wait for the result, then take it after a short random delay.
    task automatic run_block(input logic [127:0] s, output logic [127:0] res, output int lat);
        int n;
        in_state = s;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        tick();
        in_valid = 1'b0;
        in_state = rand128();
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        res = out_state;
        repeat ($urandom_range(0, 2)) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin : main
        logic [127:0] res, s, held;
        int lat, cyc, got, seen;
        logic acc, fire;
        logic [127:0] blk_q[$];
        int acc_t[$];

        // ---- reset
        rst_n = 1'b0;
        repeat (2) tick();
        chk("reset_in_ready", 128'(in_ready), 128'd1);
        chk("reset_out_valid", 128'(out_valid), 128'd0);
        chk("reset_out_state", out_state, 128'd0);
        rst_n = 1'b1;
        tick();

        // ---- single column
        s = {96'h0, 32'h8e4da1bc};
        run_block(s, res, lat);
        chk("single_col", res, {96'h0, 32'hdb135345});
        chk("single_col_model", res, ref_inv(s));
        chk("single_col_latency", 128'(lat), 128'd4);
        chk("idle_after_take", 128'(in_ready), 128'd1);

        // ---- full state
        s = {32'h4d7ebdf8, 32'hd5d5d7d6, 32'hc6c6c6c6, 32'h01010101};
        run_block(s, res, lat);
        chk("full_state", res, {32'h2d26314c, 32'hd4d4d4d5, 32'hc6c6c6c6, 32'h01010101});
        chk("full_state_latency", 128'(lat), 128'd4);

        // ---- backpressure in DONE
        s = rand128();
        in_state = s;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("bp_latency", 128'(lat), 128'd4);
        held = out_state;
        chk("bp_result", held, ref_inv(s));
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_state = rand128();
            tick();
            chk("bp_stable", out_state, held);
            chk("bp_in_ready_low", 128'(in_ready), 128'd0);
            chk("bp_out_valid_high", 128'(out_valid), 128'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release_idle", 128'(in_ready), 128'd1);
        chk("bp_release_no_valid", 128'(out_valid), 128'd0);
        s = rand128();
        in_state = s;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("bp_next_accepted", 128'(in_ready), 128'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("bp_next_result", out_state, ref_inv(s));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // ---- reset during the second BUSY cycle
        s = rand128();
        in_state = s;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_busy_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy_out_state", out_state, 128'd0);
        chk("rst_busy_in_ready", 128'(in_ready), 128'd1);
        tick();
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("rst_no_out_pulse", 128'(seen), 128'd0);
        chk("rst_idle_after", 128'(in_ready), 128'd1);

        // ---- back-to-back with in_valid held high
        for (int i = 0; i < 3; i++) begin
            s = rand128();
            blk_q.push_back(s);
            exp_q.push_back(ref_inv(s));
        end
        out_ready = 1'b1;
        cyc = 0;
        got = 0;
        while (got < 3 && cyc < 60) begin
            in_valid = (blk_q.size() > 0);
            if (blk_q.size() > 0) in_state = blk_q[0];
            acc  = in_valid && in_ready;
            fire = out_valid && out_ready;
            if (fire && exp_q.size() > 0) begin
                chk("b2b_data", out_state, exp_q.pop_front());
                got++;
            end
            tick();
            cyc++;
            if (acc) begin
                void'(blk_q.pop_front());
                acc_t.push_back(cyc);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("b2b_results", 128'(got), 128'd3);
        chk("b2b_accepts", 128'(acc_t.size()), 128'd3);
        for (int i = 1; i < acc_t.size(); i++)
            chk("b2b_spacing", 128'(acc_t[i] - acc_t[i-1]), 128'd6);
        tick();

        // ---- random round trip through the forward MixColumns model
        for (int i = 0; i < 1000; i++) begin
            s = rand128();
            repeat ($urandom_range(0, 1)) tick();
            run_block(ref_fwd(s), res, lat);
            chk("round_trip", res, s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
